// File: rtl/hazard_pkg.sv
// Shared constants for the pipeline hazard unit: forward-select encodings and
// default widths/latency.
package hazard_pkg;

   localparam logic [1:0] FWD_RF   = 2'b00;
   localparam logic [1:0] FWD_MEWR = 2'b01;
   localparam logic [1:0] FWD_EXME = 2'b10;

   localparam int HZ_REG_W      = 5;
   localparam int HZ_MD_LATENCY = 4;
   localparam int HZ_CNT_W      = 16;

endpackage : hazard_pkg

// File: rtl/hazard_unit_if.sv
// Bundle of pipeline-register fields seen by the hazard unit and the
// forward/stall/flush controls it returns to the pipeline.
interface hazard_unit_if
   import hazard_pkg::*;
#(
   parameter int REG_W = HZ_REG_W,
   parameter int CNT_W = HZ_CNT_W
);

   logic [REG_W-1:0] id_rs;
   logic [REG_W-1:0] id_rt;
   logic             id_uses_rs;
   logic             id_uses_rt;
   logic [REG_W-1:0] id_rw;
   logic             id_wb;
   logic             id_is_md;
   logic [REG_W-1:0] id_ex_Rs;
   logic [REG_W-1:0] id_ex_Rt;
   logic [REG_W-1:0] id_ex_Rw;
   logic             id_ex_wb;
   logic             id_ex_mem_read;
   logic [REG_W-1:0] ex_me_Rw;
   logic [REG_W-1:0] me_wr_Rw;
   logic             ex_me_wb;
   logic             me_wr_wb;
   logic             branch_taken;

   logic [1:0]       forward_a;
   logic [1:0]       forward_b;
   logic             stall_pc;
   logic             stall_if_id;
   logic             flush_if_id;
   logic             bubble_id_ex;
   logic             md_busy;
   logic             md_done;
   logic [CNT_W-1:0] stall_cnt;
   logic [CNT_W-1:0] flush_cnt;

   modport master (
      output id_rs, id_rt, id_uses_rs, id_uses_rt, id_rw, id_wb, id_is_md,
             id_ex_Rs, id_ex_Rt, id_ex_Rw, id_ex_wb, id_ex_mem_read,
             ex_me_Rw, me_wr_Rw, ex_me_wb, me_wr_wb, branch_taken,
      input  forward_a, forward_b, stall_pc, stall_if_id, flush_if_id,
             bubble_id_ex, md_busy, md_done, stall_cnt, flush_cnt
   );

   modport slave (
      input  id_rs, id_rt, id_uses_rs, id_uses_rt, id_rw, id_wb, id_is_md,
             id_ex_Rs, id_ex_Rt, id_ex_Rw, id_ex_wb, id_ex_mem_read,
             ex_me_Rw, me_wr_Rw, ex_me_wb, me_wr_wb, branch_taken,
      output forward_a, forward_b, stall_pc, stall_if_id, flush_if_id,
             bubble_id_ex, md_busy, md_done, stall_cnt, flush_cnt
   );

endinterface : hazard_unit_if

// File: rtl/hazard_unit_forward_select.sv
// Per-operand EX-stage forward select: the youngest matching writer wins and
// register 0 never forwards.
module forward_select
   import hazard_pkg::*;
#(
   parameter int REG_W = HZ_REG_W
) (
   input  logic [REG_W-1:0] src,
   input  logic [REG_W-1:0] ex_me_rw,
   input  logic             ex_me_wb,
   input  logic [REG_W-1:0] me_wr_rw,
   input  logic             me_wr_wb,
   output logic [1:0]       sel
);

   always_comb begin
      sel = FWD_RF;
      if (src != '0) begin
         if (ex_me_wb && (ex_me_rw == src)) begin
            sel = FWD_EXME;
         end else if (me_wr_wb && (me_wr_rw == src)) begin
            sel = FWD_MEWR;
         end
      end
   end

endmodule : forward_select

// File: rtl/hazard_unit.sv
// Hazard control for the 5-stage pipeline: operand forwarding, load-use and
// mul/div stalls, branch flush, and saturating stall/flush event counters.
module hazard_unit
   import hazard_pkg::*;
#(
   parameter int REG_W      = HZ_REG_W,
   parameter int MD_LATENCY = HZ_MD_LATENCY,
   parameter int CNT_W      = HZ_CNT_W
) (
   input logic          clk,
   input logic          rst_n,
   hazard_unit_if.slave hz
);

   localparam int MDC_W = $clog2(MD_LATENCY + 1);

   logic [MDC_W-1:0] md_cnt_q, md_cnt_d;
   logic [REG_W-1:0] md_rw_q, md_rw_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

   logic md_busy;
   logic load_use;
   logic md_raw;
   logic md_waw;
   logic md_hazard;
   logic stall;
   logic md_issue;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                               input logic              en);
      if (en && (v != '1)) begin
         return v + CNT_W'(1);
      end
      return v;
   endfunction

   forward_select #(.REG_W(REG_W)) u_fwd_a (
      .src      (hz.id_ex_Rs),
      .ex_me_rw (hz.ex_me_Rw),
      .ex_me_wb (hz.ex_me_wb),
      .me_wr_rw (hz.me_wr_Rw),
      .me_wr_wb (hz.me_wr_wb),
      .sel      (hz.forward_a)
   );

   forward_select #(.REG_W(REG_W)) u_fwd_b (
      .src      (hz.id_ex_Rt),
      .ex_me_rw (hz.ex_me_Rw),
      .ex_me_wb (hz.ex_me_wb),
      .me_wr_rw (hz.me_wr_Rw),
      .me_wr_wb (hz.me_wr_wb),
      .sel      (hz.forward_b)
   );

   always_comb begin
      md_busy  = (md_cnt_q != '0);
      load_use = hz.id_ex_mem_read && (hz.id_ex_Rw != '0) &&
                 ((hz.id_uses_rs && (hz.id_rs == hz.id_ex_Rw)) ||
                  (hz.id_uses_rt && (hz.id_rt == hz.id_ex_Rw)));
      md_raw   = (md_rw_q != '0) &&
                 ((hz.id_uses_rs && (hz.id_rs == md_rw_q)) ||
                  (hz.id_uses_rt && (hz.id_rt == md_rw_q)));
      md_waw   = (md_rw_q != '0) && hz.id_wb && (hz.id_rw == md_rw_q);
      // A second mul/div while busy is a structural hazard, so issue never overlaps busy.
      md_hazard = md_busy && (hz.id_is_md || md_raw || md_waw);
      stall     = (load_use || md_hazard) && !hz.branch_taken;
      md_issue  = hz.id_is_md && !stall && !hz.branch_taken;
   end

   always_comb begin
      md_cnt_d = md_cnt_q;
      md_rw_d  = md_rw_q;
      if (md_issue) begin
         md_cnt_d = MDC_W'(MD_LATENCY);
         md_rw_d  = hz.id_rw;
      end else if (md_busy) begin
         md_cnt_d = md_cnt_q - MDC_W'(1);
      end
      stall_cnt_d = sat_inc(stall_cnt_q, stall);
      flush_cnt_d = sat_inc(flush_cnt_q, hz.branch_taken);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         md_cnt_q    <= '0;
         md_rw_q     <= '0;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         md_cnt_q    <= md_cnt_d;
         md_rw_q     <= md_rw_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign hz.stall_pc     = stall;
   assign hz.stall_if_id  = stall;
   assign hz.flush_if_id  = hz.branch_taken;
   assign hz.bubble_id_ex = stall || hz.branch_taken;
   assign hz.md_busy      = md_busy;
   assign hz.md_done      = (md_cnt_q == MDC_W'(1));
   assign hz.stall_cnt    = stall_cnt_q;
   assign hz.flush_cnt    = flush_cnt_q;

endmodule : hazard_unit
